// File: rtl/store_rmw_unit.sv
// Store narrowing unit: sub-word stores become read-modify-write cycles on a word-only data memory.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word stores complete with MisalignErr and no memory access.
module store_rmw_unit #(
    parameter int unsigned MEM_READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_store_req,
    input  logic [1:0]  i_store_size,
    input  logic [31:0] i_address,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misalign_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_read,
    input  logic [31:0] i_mem_read_data,
    output logic        o_mem_write,
    output logic [31:0] o_mem_write_data
);
    localparam int unsigned CNT_W    = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;
    localparam int unsigned WAIT_INI = (MEM_READ_LATENCY > 1) ? MEM_READ_LATENCY - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_is_byte;
    logic [1:0]         r_lane;
    logic [15:0]        r_data;
    logic               w_capture;
    logic               w_is_word;
    logic               w_trap;
    logic               w_misalign_nxt;
    logic [31:0]        w_merged;

    // Replace the addressed lane of the fetched word, keep the other bytes
    always_comb begin
        w_merged = i_mem_read_data;
        if (r_is_byte) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_data[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_data;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_capture      = 1'b0;
        w_misalign_nxt = 1'b0;
        w_is_word      = (i_store_size == 2'b00) || (i_store_size == 2'b11);
        w_trap         = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_trap = ((i_store_size == 2'b01) && i_address[0]) ||
                 (w_is_word && (i_address[1:0] != 2'b00));
`endif
        case (r_state)
            S_IDLE: begin
                if (i_store_req) begin
                    w_capture = 1'b1;
                    if (w_trap) begin
                        w_state_nxt    = S_DONE;
                        w_misalign_nxt = 1'b1;
                    end else if (w_is_word) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (MEM_READ_LATENCY > 1) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(WAIT_INI);
                end else begin
                    w_state_nxt = S_MERGE;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_MERGE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_MERGE: w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_is_byte        <= 1'b0;
            r_lane           <= 2'b00;
            r_data           <= 16'h0000;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_misalign_err   <= 1'b0;
            o_mem_addr       <= 32'h0000_0000;
            o_mem_read       <= 1'b0;
            o_mem_write      <= 1'b0;
            o_mem_write_data <= 32'h0000_0000;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            o_busy         <= (w_state_nxt != S_IDLE);
            o_done         <= (w_state_nxt == S_DONE);
            o_misalign_err <= w_misalign_nxt;
            o_mem_read     <= (w_state_nxt == S_READ);
            o_mem_write    <= (w_state_nxt == S_WRITE);
            if (w_capture) begin
                r_is_byte        <= (i_store_size == 2'b10);
                r_lane           <= i_address[1:0];
                r_data           <= i_store_data[15:0];
                o_mem_addr       <= {i_address[31:2], 2'b00};
                o_mem_write_data <= i_store_data;
            end else if (r_state == S_MERGE) begin
                o_mem_write_data <= w_merged;
            end
        end
    end
endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed cases plus random stores against a word-memory model.
// Build with MISALIGN_TRAP_EN defined to check the trap configuration.
module tb_store_rmw_unit;
    localparam int unsigned L = 3;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        o_busy;
    logic        o_done;
    logic        o_misalign_err;
    logic [31:0] o_mem_addr;
    logic        o_mem_read;
    logic [31:0] mem_rdata;
    logic        o_mem_write;
    logic [31:0] o_mem_write_data;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [L-1:0] rd_vld = '0;
    logic [5:0]  rd_idx [L];
    logic [31:0] junk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] last_wdata;

    store_rmw_unit #(.MEM_READ_LATENCY(L)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_store_req      (req),
        .i_store_size     (size),
        .i_address        (addr),
        .i_store_data     (data),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_misalign_err   (o_misalign_err),
        .o_mem_addr       (o_mem_addr),
        .o_mem_read       (o_mem_read),
        .i_mem_read_data  (mem_rdata),
        .o_mem_write      (o_mem_write),
        .o_mem_write_data (o_mem_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data valid L cycles after the read strobe, garbage otherwise
    always @(posedge clk) begin
        junk      <= $urandom;
        rd_vld[0] <= o_mem_read;
        rd_idx[0] <= o_mem_addr[7:2];
        for (int i = 1; i < int'(L); i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_idx[i] <= rd_idx[i-1];
        end
    end
    assign mem_rdata = rd_vld[L-1] ? mem[rd_idx[L-1]] : junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] old, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] d);
        int sh;
        logic [31:0] m;
        if (sz == 2'b10) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'h0000_00FF << sh;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            m  = 32'h0000_FFFF << sh;
        end else begin
            return d;
        end
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        bit mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = ((sz == 2'b01) && a[0]) || (((sz == 2'b00) || (sz == 2'b11)) && (a[1:0] != 2'b00));
`endif
        return mis;
    endfunction

    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bit          word;
        bit          mis;
        int          exp_lat;
        int          nrd;
        int          nwr;
        int          done_cyc;
        logic [31:0] expw;
        word     = (sz == 2'b00) || (sz == 2'b11);
        mis      = model_misaligned(sz, a);
        expw     = model_word(ref_mem[a[7:2]], sz, a, d);
        exp_lat  = mis ? 1 : (word ? 2 : 3 + int'(L));
        nrd      = 0;
        nwr      = 0;
        done_cyc = 0;
        last_wdata = 32'h0;
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 32'h0);
        req = 1'b1; size = sz; addr = a; data = d;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            req  = 1'b0;
            size = 2'($urandom);
            addr = $urandom;
            data = $urandom;
            chk("busy", 32'(o_busy), 32'h1);
            chk("strobe_excl", 32'(o_mem_read & o_mem_write), 32'h0);
            if (o_mem_read) begin
                nrd++;
                chk("rd_cycle", 32'(c), 32'h1);
                chk("rd_addr", o_mem_addr, {a[31:2], 2'b00});
            end
            if (o_mem_write) begin
                nwr++;
                last_wdata = o_mem_write_data;
                mem[o_mem_addr[7:2]] = o_mem_write_data;
                chk("wr_cycle", 32'(c), 32'(exp_lat - 1));
                chk("wr_addr", o_mem_addr, {a[31:2], 2'b00});
                chk("wr_data", o_mem_write_data, expw);
            end
            if (o_done) begin
                done_cyc = c;
                chk("misalign", 32'(o_misalign_err), 32'(mis));
            end
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_lat));
        chk("n_reads", 32'(nrd), 32'((!mis && !word) ? 1 : 0));
        chk("n_writes", 32'(nwr), 32'(mis ? 0 : 1));
        if (!mis) ref_mem[a[7:2]] = expw;
    endtask

    initial begin
        int          nrd;
        int          nwr;
        int          ndone;
        int          nlow;
        int          dc [2];
        logic [31:0] wd [2];

        rst = 1'b1; req = 1'b0; size = 2'b00; addr = 32'h0; data = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({o_busy, o_done, o_misalign_err, o_mem_read, o_mem_write}), 32'h0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_wdata", o_mem_write_data, 32'h0);
        rst = 1'b0;

        // Word store bypasses the read
        do_store(2'b00, 32'h10, 32'hDEAD_BEEF);
        chk("t1_wdata", last_wdata, 32'hDEAD_BEEF);

        // Byte store into lane 3
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        do_store(2'b10, 32'h13, 32'h0000_00AB);
        chk("t2_wdata", last_wdata, 32'hAB22_3344);

        // Halfword stores into upper and lower halves
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
        do_store(2'b01, 32'h22, 32'h0000_CAFE);
        chk("t3_hi", last_wdata, 32'hCAFE_3344);
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
        do_store(2'b01, 32'h20, 32'h0000_CAFE);
        chk("t3_lo", last_wdata, 32'h1122_CAFE);

        // Reset in WAIT (cycle 3) and MERGE (cycle 4) aborts without writing
        for (int r = 3; r <= 4; r++) begin
            mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
            @(negedge clk);
            req = 1'b1; size = 2'b10; addr = 32'h13; data = 32'h0000_00AB;
            for (int c = 1; c <= r; c++) begin
                @(negedge clk);
                req = 1'b0;
                chk("abort_no_wr", 32'(o_mem_write), 32'h0);
            end
            rst = 1'b1;
            @(negedge clk);
            chk("abort_ctrl", 32'({o_busy, o_done, o_misalign_err, o_mem_read, o_mem_write}), 32'h0);
            chk("abort_addr", o_mem_addr, 32'h0);
            chk("abort_wdata", o_mem_write_data, 32'h0);
            chk("abort_mem", mem[4], 32'h1122_3344);
            rst = 1'b0;
        end
        do_store(2'b10, 32'h13, 32'h0000_00AB);
        chk("t4_after", last_wdata, 32'hAB22_3344);

        // Held request: two back-to-back RMW sequences, operands captured per acceptance
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        nrd = 0; nwr = 0; ndone = 0; nlow = 0;
        dc[0] = 0; dc[1] = 0; wd[0] = 32'h0; wd[1] = 32'h0;
        @(negedge clk);
        req = 1'b1; size = 2'b10; addr = 32'h11; data = 32'h0000_0055;
        for (int c = 1; c <= 40 && ndone < 2; c++) begin
            @(negedge clk);
            if (c == 2) data = 32'h0000_0066;
            chk("hold_excl", 32'(o_mem_read & o_mem_write), 32'h0);
            if (o_mem_read) nrd++;
            if (o_mem_write) begin
                if (nwr < 2) wd[nwr] = o_mem_write_data;
                nwr++;
                mem[o_mem_addr[7:2]] = o_mem_write_data;
            end
            if (!o_busy && ndone == 1) nlow++;
            if (o_done) begin
                if (ndone < 2) dc[ndone] = c;
                ndone++;
            end
        end
        req = 1'b0;
        chk("hold_reads", 32'(nrd), 32'h2);
        chk("hold_writes", 32'(nwr), 32'h2);
        chk("hold_done0", 32'(dc[0]), 32'(3 + L));
        chk("hold_done1", 32'(dc[1]), 32'(2 * (3 + L) + 1));
        chk("hold_idle_gap", 32'(nlow), 32'h1);
        chk("hold_wd0", wd[0], 32'h1122_5544);
        chk("hold_wd1", wd[1], 32'h1122_6644);
        ref_mem[4] = 32'h1122_6644;

        // Misaligned halfword
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
        do_store(2'b01, 32'h21, 32'h0000_BEEF);
`ifndef MISALIGN_TRAP_EN
        chk("t6_wdata", last_wdata, 32'h1122_BEEF);
`endif

        // Random stores against the reference memory
        for (int n = 0; n < 40; n++) begin
            do_store(2'($urandom), 32'($urandom_range(0, 255)), $urandom);
        end
        for (int i = 0; i < 64; i++) begin
            chk("final_mem", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
